// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, BCD time layout
// and the digit arithmetic used by the counter.
package stopwatch_pkg;

  // Operating states of the stopwatch.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  // Largest value a BCD digit may hold.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Number of BCD digits in the displayed time (SS.hh).
  localparam int unsigned BCD_DIGITS = 4;

  // Displayed time, most significant digit first (matches displayed_number).
  typedef struct packed {
    logic [3:0] tens_sec;
    logic [3:0] sec;
    logic [3:0] tenths;
    logic [3:0] hundredths;
  } bcd_time_t;

  // Add one hundredth with ripple carry; 99.99 rolls over to 00.00.
  // A digit at or above the maximum is treated as full so it always returns to 0.
  function automatic bcd_time_t bcd_increment(input bcd_time_t t);
    logic [BCD_DIGITS-1:0][3:0] d;
    logic                       carry;
    d     = t;
    carry = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (carry) begin
        if (d[i] >= BCD_DIGIT_MAX) begin
          d[i] = 4'd0;
        end else begin
          d[i]  = d[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return bcd_time_t'(d);
  endfunction

  // True when every digit is at its maximum (99.99).
  function automatic logic bcd_is_max(input bcd_time_t t);
    return (t.tens_sec == BCD_DIGIT_MAX) && (t.sec == BCD_DIGIT_MAX) &&
           (t.tenths == BCD_DIGIT_MAX) && (t.hundredths == BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debounce and
// a single-cycle pulse on each accepted press (0->1 of the debounced level).
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   button - raw asynchronous push-button, active-high
//   press  - registered one-cycle pulse per debounced press
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, then accept a new level only after it has differed from the
  // current level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      press  <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          press   <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch with start/stop and clear buttons counting SS.hh in BCD.
//
// Ports:
//   clock            - 100 MHz system clock, rising edge
//   reset            - asynchronous, active-high
//   btn_start_stop   - raw push-button: start / pause / resume
//   btn_clear        - raw push-button: stop and zero the count
//   displayed_number - BCD SS.hh [15:12] tens s, [11:8] s, [7:4] tenths, [3:0] hundredths
//   running          - high while in RUNNING
//   wrap             - one-cycle pulse on the 99.99 -> 00.00 rollover
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_CYCLES     = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] displayed_number,
  output logic        running,
  output logic        wrap
);

  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

  logic               ss_press;
  logic               clr_press;
  logic               tick;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  bcd_time_t          count_q, count_d;
  logic               running_d;
  logic               wrap_d;

  // One conditioner per button.
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clock  (clock),
    .reset  (reset),
    .button (btn_start_stop),
    .press  (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clock  (clock),
    .reset  (reset),
    .button (btn_clear),
    .press  (clr_press)
  );

  // Hundredth-second tick: last prescaler count while running.
  assign tick = (state_q == RUNNING) && (presc_q == PRESC_LAST);

  // State, prescaler, count and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      running <= running_d;
      wrap    <= wrap_d;
    end
  end

  // Next-state and datapath; clear overrides everything, including a tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;

    // Prescaler only moves in RUNNING, so PAUSED keeps the partial period.
    if (state_q == RUNNING) begin
      if (tick) begin
        presc_d = '0;
        count_d = bcd_increment(count_q);
        wrap_d  = bcd_is_max(count_q);
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    case (state_q)
      IDLE:    if (ss_press) state_d = RUNNING;
      RUNNING: if (ss_press) state_d = PAUSED;
      PAUSED:  if (ss_press) state_d = RUNNING;
      default: state_d = IDLE;
    endcase

    if (clr_press) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
      wrap_d  = 1'b0;
    end

    running_d = (state_d == RUNNING);
  end

  assign displayed_number = count_q;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter TICK_CYCLES, 1000000, clock cycles per hundredth-second tick.
REQ-003 SHALL have port clock  input  1  100 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_start_stop  input  1  raw, asynchronous push-button, active-high.
REQ-006 SHALL have port btn_clear  input  1  raw, asynchronous push-button, active-high.
REQ-007 SHALL have port displayed_number  output  16  elapsed time as BCD SS.hh: [15:12] tens of seconds, [11:8] seconds, [7:4] tenths, [3:0] hundredths; feeds the 7-segment display driver.
REQ-008 SHALL have port running  output  1  high while in state RUNNING.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse when the count rolls over from 99.99 to 00.00.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-011 SHALL change a debounced button level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the stability count.
REQ-012 SHALL generate a one-cycle press pulse on each 0->1 transition of a debounced level; releases generate nothing.
REQ-013 SHALL implement states IDLE, RUNNING, PAUSED; transitions take effect on the cycle after the press pulse.
REQ-014 SHALL transition IDLE->RUNNING and PAUSED->RUNNING on start_stop pulse, RUNNING->PAUSED on start_stop pulse.
REQ-015 SHALL, on clear pulse in any state, go to IDLE, zero displayed_number and zero the prescaler.
REQ-016 SHALL give clear priority when clear and start_stop pulses occur in the same cycle (result IDLE, count zero).
REQ-017 SHALL advance the prescaler 0..TICK_CYCLES-1 only in RUNNING and assert an internal tick when it equals TICK_CYCLES-1, then wrap it to 0.
REQ-018 SHALL hold the prescaler value in PAUSED so a resumed run completes the partial period.
REQ-019 SHALL increment the BCD count by one hundredth on each tick, each digit wrapping 9->0 with a carry into the next digit; digits never hold values above 9.
REQ-020 SHALL, on a tick at 99.99, load 00.00, pulse wrap for exactly that update cycle, and remain RUNNING.
REQ-021 SHALL update displayed_number registered, in the cycle after the tick; no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, on reset assertion, immediately force state IDLE, displayed_number 16'h0000, running 0, wrap 0, prescaler 0, debounced levels 0, debounce counters 0, synchronizers 0.
REQ-023 SHALL, after reset release, require a full debounce interval before any press is recognised, even if a button is held through reset.

Structure
REQ-024 SHALL place the state encoding (IDLE, RUNNING, PAUSED) and the BCD digit maximum constant (9) in shared package stopwatch_pkg.
REQ-025 SHALL implement synchronizer, debounce and press-pulse generation in sub-module button_debounce, instantiated once per button, parameterised by DEBOUNCE_CYCLES.
REQ-026 SHALL size the prescaler and debounce counters as clog2 of their parameters.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=5)
REQ-027 SHALL cover: start_stop held 20 cycles from IDLE -> running=1 within 2+4+2 cycles; after 50 further cycles displayed_number=16'h0010.
REQ-028 SHALL cover: start_stop glitch high 3 cycles -> no state change, displayed_number stays 16'h0000.
REQ-029 SHALL cover: pause after 12 cycles of RUNNING (value 16'h0002, prescaler 2), wait 100 cycles -> value unchanged; resume -> next tick exactly 3 cycles after running reasserts.
REQ-030 SHALL cover: preload to 16'h9999 via run, next tick -> displayed_number=16'h0000, wrap high exactly 1 cycle, running stays 1.
REQ-031 SHALL cover: start_stop and clear pressed simultaneously while RUNNING at 16'h0123 -> state IDLE, displayed_number=16'h0000, running=0.
REQ-032 SHALL cover: reset asserted mid-count (16'h0457) asynchronously between clock edges -> all outputs zero before next clock edge; held button not recognised until 4 stable cycles after release of reset.
